// File: rtl/nios_system_com_nios_oci_dct_packer_pkg.sv
// Shared widths, FSM state encoding and frame payload layout for the OCI trace atom packer.
package nios_system_com_nios_oci_dct_pkg;

    localparam int unsigned DCT_W     = 30;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ATOM_W    = 2;
    localparam int unsigned MAX_ATOMS = 15;
    localparam int unsigned FRM_W     = CNT_W + DCT_W;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FILL,
        ST_FULL_WAIT
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [DCT_W-1:0] buffer;
    } frame_t;

endpackage

// File: rtl/nios_system_com_nios_oci_dct_packer_if.sv
// Valid/ready frame channel from the packer to the trace FIFO.
interface nios_system_com_nios_oci_dct_packer_if;
    import nios_system_com_nios_oci_dct_pkg::*;

    logic             frm_valid;
    logic [FRM_W-1:0] frm_data;
    logic             frm_ready;

    modport master (output frm_valid, output frm_data, input frm_ready);
    modport slave  (input frm_valid, input frm_data, output frm_ready);

endinterface

// File: rtl/nios_system_com_nios_oci_dct_packer_frame_reg.sv
// Single-entry output frame register; holds a frame stable until the FIFO accepts it.
module nios_system_com_nios_oci_dct_frame_reg
    import nios_system_com_nios_oci_dct_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load_i,
    input  frame_t                               data_i,
    output logic                                 free_c,
    nios_system_com_nios_oci_dct_packer_if.master frm
);

    logic   valid_q, valid_d;
    frame_t data_q,  data_d;

    // Register can take a new frame when empty or when its current frame leaves this cycle.
    assign free_c = !valid_q || frm.frm_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && free_c) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && frm.frm_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign frm.frm_valid = valid_q;
    assign frm.frm_data  = FRM_W'(data_q);

endmodule

// File: rtl/nios_system_com_nios_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom frames with flush, back-pressure and drop accounting.
module nios_system_com_nios_oci_dct_packer #(
    parameter int unsigned DCT_W  = 30,
    parameter int unsigned DROP_W = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           trace_en,
    input  logic                                           atom_valid,
    input  logic [1:0]                                     atom,
    input  logic                                           flush,
    output logic [DCT_W-1:0]                               dct_buffer,
    output logic [3:0]                                     dct_count,
    output logic                                           overflow,
    output logic [DROP_W-1:0]                              drop_cnt,
    nios_system_com_nios_oci_dct_packer_if.master          frm
);
    import nios_system_com_nios_oci_dct_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ATOMS);

    state_e             state_q, state_d;
    logic [DCT_W-1:0]   buf_q,   buf_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               pend_q,  pend_d;
    logic               ovf_q,   ovf_d;
    logic [DROP_W-1:0]  drop_q,  drop_d;
    logic               te_q;

    logic               accept_c;
    logic               te_fall_c;
    logic               free_c;
    logic               load_c;
    frame_t             frame_c;
    logic [DCT_W-1:0]   post_buf_c;
    logic [CNT_W-1:0]   post_cnt_c;

    assign accept_c   = trace_en && atom_valid;
    assign te_fall_c  = te_q && !trace_en;
    assign post_buf_c = accept_c ? {buf_q[DCT_W-3:0], atom} : buf_q;
    assign post_cnt_c = accept_c ? CNT_W'(cnt_q + CNT_W'(1)) : cnt_q;

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;
        drop_d  = drop_q;
        load_c  = 1'b0;
        frame_c = '{count: cnt_q, buffer: buf_q};
        state_d = state_q;

        case (state_q)
            ST_FULL_WAIT: begin
                if (free_c) begin
                    // Held frame moves out; a same-cycle atom opens the next buffer.
                    load_c = 1'b1;
                    pend_d = 1'b0;
                    if (accept_c) begin
                        buf_d = DCT_W'(atom);
                        cnt_d = CNT_W'(1);
                    end else begin
                        buf_d = '0;
                        cnt_d = '0;
                    end
                end else if (accept_c) begin
                    ovf_d = 1'b1;
                    if (drop_q != {DROP_W{1'b1}}) begin
                        drop_d = DROP_W'(drop_q + DROP_W'(1));
                    end
                end
            end
            default: begin
                if ((post_cnt_c == CNT_MAX) ||
                    ((flush || te_fall_c || pend_q) && (post_cnt_c != '0))) begin
                    frame_c = '{count: post_cnt_c, buffer: post_buf_c};
                    if (free_c) begin
                        load_c = 1'b1;
                        buf_d  = '0;
                        cnt_d  = '0;
                        pend_d = 1'b0;
                    end else begin
                        buf_d  = post_buf_c;
                        cnt_d  = post_cnt_c;
                        pend_d = (post_cnt_c != CNT_MAX);
                    end
                end else begin
                    buf_d = post_buf_c;
                    cnt_d = post_cnt_c;
                end
            end
        endcase

        if (cnt_d == '0) begin
            state_d = ST_EMPTY;
        end else if (cnt_d == CNT_MAX) begin
            state_d = ST_FULL_WAIT;
        end else begin
            state_d = ST_FILL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            buf_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
            te_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
            te_q    <= trace_en;
        end
    end

    nios_system_com_nios_oci_dct_frame_reg u_frame_reg (
        .clk    (clk),
        .reset  (reset),
        .load_i (load_c),
        .data_i (frame_c),
        .free_c (free_c),
        .frm    (frm)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_nios_system_com_nios_oci_dct_packer.sv
// Table-driven bench for the trace atom packer with a frame scoreboard on the FIFO side.
module tb_nios_system_com_nios_oci_dct_packer;

    typedef struct {
        bit          te;
        bit          av;
        logic [1:0]  atom;
        bit          fl;
        bit          rdy;
        logic [3:0]  exp_cnt;
        logic [29:0] exp_buf;
        bit          push;
        logic [33:0] frame;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        trace_en, atom_valid, flush;
    logic [1:0]  atom;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [33:0] sb[$];
    vec_t        tbl[$];

    nios_system_com_nios_oci_dct_packer_if frm_if();

    nios_system_com_nios_oci_dct_packer #(.DCT_W(30), .DROP_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .trace_en   (trace_en),
        .atom_valid (atom_valid),
        .atom       (atom),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .frm        (frm_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit te, bit av, logic [1:0] a, bit fl, bit rdy,
                                logic [3:0] c, logic [29:0] b, bit push, logic [33:0] f);
        vec_t v;
        v.te = te; v.av = av; v.atom = a; v.fl = fl; v.rdy = rdy;
        v.exp_cnt = c; v.exp_buf = b; v.push = push; v.frame = f;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string nm);
        trace_en         = v.te;
        atom_valid       = v.av;
        atom             = v.atom;
        flush            = v.fl;
        frm_if.frm_ready = v.rdy;
        if (v.push) sb.push_back(v.frame);
        @(posedge clk); #1;
        chk({nm, " count"},  64'(dct_count),  64'(v.exp_cnt));
        chk({nm, " buffer"}, 64'(dct_buffer), 64'(v.exp_buf));
    endtask

    // FIFO side: a frame is consumed at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (!reset && frm_if.frm_valid && frm_if.frm_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_frame: got %h expected none", frm_if.frm_data);
            end else begin
                logic [33:0] e;
                e = sb.pop_front();
                if (frm_if.frm_data !== e) begin
                    bad++;
                    $display("FAIL frame_data: got %h expected %h", frm_if.frm_data, e);
                end
            end
        end
    end

    initial begin
        logic [29:0] mb;
        logic [33:0] f1, f2;
        logic [1:0]  a;

        reset = 1'b1; trace_en = 1'b0; atom_valid = 1'b0; atom = 2'b00;
        flush = 1'b0; frm_if.frm_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst count",    64'(dct_count),       64'd0);
        chk("rst buffer",   64'(dct_buffer),      64'd0);
        chk("rst valid",    64'(frm_if.frm_valid), 64'd0);
        chk("rst data",     64'(frm_if.frm_data),  64'd0);
        chk("rst overflow", 64'(overflow),        64'd0);
        chk("rst drops",    64'(drop_cnt),        64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full frame of 2'b01 atoms
        mb = '0;
        for (int i = 1; i <= 14; i++) begin
            mb = {mb[27:0], 2'b01};
            tbl.push_back(mk(1, 1, 2'b01, 0, 1, 4'(i), mb, 0, '0));
        end
        tbl.push_back(mk(1, 1, 2'b01, 0, 1, 4'd0, 30'd0, 1, {4'hF, 30'h15555555}));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0, 0, '0));
        // Partial frame via flush, then a flush with nothing buffered
        tbl.push_back(mk(1, 1, 2'b11, 0, 1, 4'd1, 30'h3,  0, '0));
        tbl.push_back(mk(1, 1, 2'b10, 0, 1, 4'd2, 30'hE,  0, '0));
        tbl.push_back(mk(1, 1, 2'b01, 0, 1, 4'd3, 30'h39, 0, '0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 1, 4'd0, 30'd0,  1, {4'h3, 30'h39}));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0,  0, '0));
        tbl.push_back(mk(1, 0, 2'b00, 1, 1, 4'd0, 30'd0,  0, '0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0,  0, '0));
        // Five atoms then trace_en falls; atoms afterwards are ignored
        mb = '0;
        for (int i = 1; i <= 5; i++) begin
            mb = {mb[27:0], 2'b10};
            tbl.push_back(mk(1, 1, 2'b10, 0, 1, 4'(i), mb, 0, '0));
        end
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 4'd0, 30'd0, 1, {4'h5, 30'h2AA}));
        tbl.push_back(mk(0, 1, 2'b11, 0, 1, 4'd0, 30'd0, 0, '0));
        tbl.push_back(mk(0, 1, 2'b01, 1, 1, 4'd0, 30'd0, 0, '0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0, 0, '0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Back-pressure: 30 atoms with FIFO stalled, then 5 dropped atoms
        mb = '0; f1 = '0; f2 = '0;
        for (int i = 0; i < 30; i++) begin
            a  = 2'(i % 4);
            mb = {mb[27:0], a};
            if (i == 14) begin
                f1 = {4'hF, mb};
                apply(mk(1, 1, a, 0, 0, 4'd0, 30'd0, 1, f1), "bp fill1");
                mb = '0;
            end else if (i == 29) begin
                f2 = {4'hF, mb};
                apply(mk(1, 1, a, 0, 0, 4'd15, mb, 1, f2), "bp fill2");
            end else begin
                apply(mk(1, 1, a, 0, 0, 4'((i % 15) + 1), mb, 0, '0), "bp fill");
            end
        end
        for (int i = 0; i < 5; i++) apply(mk(1, 1, 2'b11, 0, 0, 4'd15, f2[29:0], 0, '0), "bp drop");
        chk("bp overflow",  64'(overflow),         64'd1);
        chk("bp drops",     64'(drop_cnt),         64'd5);
        chk("bp valid",     64'(frm_if.frm_valid), 64'd1);
        chk("bp held data", 64'(frm_if.frm_data),  64'(f1));

        // Ready rises together with an atom: held frame moves, atom starts new buffer
        apply(mk(1, 1, 2'b10, 0, 1, 4'd1, 30'h2, 0, '0), "fw release");
        chk("fw next data", 64'(frm_if.frm_data), 64'(f2));
        chk("fw drops",     64'(drop_cnt),        64'd5);
        apply(mk(1, 0, 2'b00, 0, 1, 4'd1, 30'h2, 0, '0), "fw idle");
        apply(mk(1, 0, 2'b00, 1, 1, 4'd0, 30'd0, 1, {4'h1, 30'h2}), "fw flush");
        apply(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0, 0, '0), "fw idle2");
        chk("fw overflow sticky", 64'(overflow), 64'd1);

        // Reset mid-frame with a frame waiting
        for (int i = 0; i < 24; i++) begin
            trace_en = 1'b1; atom_valid = 1'b1; atom = 2'b01; flush = 1'b0;
            frm_if.frm_ready = 1'b0;
            @(posedge clk); #1;
        end
        atom_valid = 1'b0;
        chk("mid count", 64'(dct_count),        64'd9);
        chk("mid valid", 64'(frm_if.frm_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst count",    64'(dct_count),        64'd0);
        chk("arst buffer",   64'(dct_buffer),       64'd0);
        chk("arst valid",    64'(frm_if.frm_valid), 64'd0);
        chk("arst data",     64'(frm_if.frm_data),  64'd0);
        chk("arst overflow", 64'(overflow),         64'd0);
        chk("arst drops",    64'(drop_cnt),         64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) apply(mk(1, 0, 2'b00, 0, 1, 4'd0, 30'd0, 0, '0), "post rst");
        chk("post rst valid", 64'(frm_if.frm_valid), 64'd0);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_system_com_nios_oci_dct_packer.md
NIOS_SYSTEM_COM_NIOS_OCI_DCT_PACKER -- requirements
Module: nios_system_com_nios_oci_dct_packer

Interface
REQ-001 Parameter: DCT_W, 30, width of the packed trace buffer (15 two-bit atoms).
REQ-002 Parameter: DROP_W, 8, width of the saturating dropped-atom counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-high reset.
REQ-006 Port: trace_en  in  1  packing enable; its 1->0 transition acts as a flush.
REQ-007 Port: atom_valid  in  1  qualifies atom this cycle.
REQ-008 Port: atom  in  2  compressed trace atom (taken/not-taken/exception/sync code).
REQ-009 Port: flush  in  1  single-cycle request to emit a partial buffer.
REQ-010 Port: dct_buffer  out  30  live accumulator contents, to the OCI test-bench monitor.
REQ-011 Port: dct_count  out  4  number of atoms currently in dct_buffer, 0..15.
REQ-012 Port: frm_valid  out  1  packed frame available to the trace FIFO.
REQ-013 Port: frm_data  out  34  {count[3:0], buffer[29:0]} of the emitted frame.
REQ-014 Port: frm_ready  in  1  trace FIFO accepts frm_data when frm_valid && frm_ready.
REQ-015 Port: overflow  out  1  sticky; set on any dropped atom.
REQ-016 Port: drop_cnt  out  DROP_W  saturating count of dropped atoms.

Function
REQ-017 The module SHALL accept an atom only when trace_en && atom_valid; otherwise atom is ignored.
REQ-018 An accepted atom SHALL shift in at the LSBs: buffer <= {buffer[27:0], atom}, count <= count+1.
REQ-019 The accumulator FSM SHALL have states EMPTY (count 0), FILL (1..14) and FULL_WAIT (15, blocked).
REQ-020 Emit condition: the post-accept count is 15, or (flush or trace_en falling) with a post-accept count >0.
REQ-021 The frame register is free when !frm_valid or (frm_valid && frm_ready) in the same cycle.
REQ-022 On emit with a free frame register, the post-accept {count, buffer} SHALL load frm_data and frm_valid SHALL be 1 the next cycle; the accumulator clears to count 0, buffer 0 (EMPTY).
REQ-023 Latency: the atom completing a frame appears on frm_data exactly 1 cycle after acceptance.
REQ-024 On emit with a busy frame register, the accumulator SHALL hold its contents; count 15 -> FULL_WAIT; partial flush stays pending until the register frees.
REQ-025 In FULL_WAIT an accepted atom SHALL be dropped: overflow <= 1 and drop_cnt increments, saturating at 2^DROP_W-1.
REQ-026 Leaving FULL_WAIT: in the cycle the register frees, the held frame transfers; an atom arriving that cycle starts the new buffer at count 1, not dropped.
REQ-027 A flush with count 0 and no accepted atom SHALL emit nothing.
REQ-028 frm_valid SHALL stay asserted and frm_data stable until accepted (no retraction).
REQ-029 dct_buffer/dct_count SHALL reflect registered accumulator state, never combinational input.
REQ-030 overflow and drop_cnt SHALL clear only on reset.

Reset
REQ-031 On reset assertion: dct_buffer 0, dct_count 0, frm_valid 0, frm_data 0, overflow 0, drop_cnt 0, FSM EMPTY, trace_en edge history 0.
REQ-032 Reset mid-frame SHALL discard accumulator and frame register contents; no frame emitted after release.

Structure
REQ-033 Package nios_system_com_nios_oci_dct_pkg SHALL hold DCT_W, count width 4, MAX_ATOMS=15, frame width 34 and the FSM state enum.
REQ-034 The frame register with its valid/ready logic SHALL be one sub-module, nios_system_com_nios_oci_dct_frame_reg; the accumulator FSM stays in the top.

Verification
REQ-035 15 atoms 2'b01 back-to-back, frm_ready=1 -> frm_valid one cycle after 15th, frm_data = {4'hF, 30'h15555555}, dct_count returns 0.
REQ-036 3 atoms 11,10,01 then flush -> frm_data = {4'h3, 30'h00000039}, no further frame on a second flush.
REQ-037 frm_ready=0, 30 atoms -> first frame held, accumulator 15 in FULL_WAIT; atoms 31..35 dropped: overflow=1, drop_cnt=5.
REQ-038 In FULL_WAIT raise frm_ready with atom_valid same cycle -> held frame emitted next cycle, dct_count=1, drop_cnt unchanged.
REQ-039 5 atoms then trace_en 1->0 -> frame with count 5 emitted; later atom_valid pulses ignored, dct_count stays 0.
REQ-040 Assert reset at count 9 with frm_valid=1 -> all outputs 0 immediately, no frame after release.
